// File: rtl/dac_sample_sched_pkg.sv
// dac_pkg: shared types and constants for the DAC sample scheduler.
package dac_pkg;
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT_HI, WAIT_LO} state_e;
  localparam int DAC_DW = 12;
  localparam int TICK_DIV_25K = 2000;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/dac_sample_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after last_i.
module rr_arbiter
  import dac_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CW = clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  last_i,
  output logic [CW-1:0]  grant_o,
  output logic           any_o
);
  logic [CW-1:0] idx;
  // Walk from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    grant_o = '0;
    idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = CW'((int'(last_i) + k) % NCH);
      if (req_i[idx]) grant_o = idx;
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/dac_sample_sched.sv
// dac_sample_sched: per-tick round-robin feeder for a shared serial DAC link.
// Define DAC_REFRESH_EN to resend the last word when no requester is valid.
module dac_sample_sched
  import dac_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW = DAC_DW,
  parameter int TICK_DIV = TICK_DIV_25K,
  parameter int BUSY_TO = 15,
  localparam int CW = clog2(NCH),
  localparam int TW = clog2(TICK_DIV),
  localparam int BW = clog2(BUSY_TO + 1)
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic              ser_start,
  output logic [DW-1:0]     ser_data,
  output logic [CW-1:0]     ser_ch,
  input  logic              ser_busy,
  output logic              overrun,
  output logic              timeout,
  input  logic              clr_err
);
`ifdef DAC_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif
  state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_q, last_d, ch_q, ch_d, grant;
  logic [DW-1:0] data_q, data_d;
  logic [BW-1:0] wcnt_q, wcnt_d;
  logic rdy_q, rdy_d, overrun_q, overrun_d, timeout_q, timeout_d;
  logic tick, any_valid, arb_win, wait_expired;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .grant_o(grant),
    .any_o  (any_valid)
  );

  assign tick = cnt_q == TW'(TICK_DIV - 1);
  assign arb_win = state_q == ARB && any_valid;
  assign wait_expired = state_q == WAIT_HI && !ser_busy && wcnt_q == BW'(BUSY_TO - 1);

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= CW'(NCH - 1);
      ch_q      <= '0;
      data_q    <= '0;
      wcnt_q    <= '0;
      rdy_q     <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      wcnt_q    <= wcnt_d;
      rdy_q     <= rdy_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = tick ? ARB : IDLE;
      ARB:     state_d = (any_valid || REFRESH) ? START : IDLE;
      START:   state_d = WAIT_HI;
      WAIT_HI: state_d = ser_busy ? WAIT_LO : wait_expired ? IDLE : WAIT_HI;
      WAIT_LO: state_d = ser_busy ? WAIT_LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ticks outside IDLE are dropped and only flagged; the counter never stalls.
  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    last_d    = arb_win ? grant : last_q;
    ch_d      = arb_win ? grant : ch_q;
    data_d    = arb_win ? req_data[int'(grant)*DW +: DW] : data_q;
    rdy_d     = state_q == ARB ? any_valid : rdy_q;
    wcnt_d    = state_q == WAIT_HI ? wcnt_q + 1'b1 : '0;
    overrun_d = (tick && state_q != IDLE) || (overrun_q && !clr_err);
    timeout_d = wait_expired || (timeout_q && !clr_err);
  end

  always_comb begin
    ser_start = state_q == START;
    req_ready = (state_q == START && rdy_q) ? NCH'(1) << ch_q : '0;
    ser_data  = data_q;
    ser_ch    = ch_q;
    overrun   = overrun_q;
    timeout   = timeout_q;
  end
endmodule

// File: tb/tb_dac_sample_sched.sv
// tb_dac_sample_sched: scoreboard bench for dac_sample_sched with a serializer busy model.
module tb_dac_sample_sched;
  localparam int NCH = 4;
  localparam int DW = 12;
  localparam int TD = 200;
  localparam int BT = 15;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] data;
    logic [3:0]  rdy;
  } exp_t;

  logic clk50 = 1'b0, rst = 1'b1, ser_busy = 1'b0, clr_err = 1'b0;
  logic [NCH-1:0] req_valid = '0, req_ready;
  logic [NCH*DW-1:0] req_data = '0;
  logic ser_start, overrun, timeout;
  logic [DW-1:0] ser_data;
  logic [1:0] ser_ch;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0, nstart = 0, cyc = 0, tick_cyc = 0, start_cyc = 0;
  int mcnt = 0, bcnt = 0, busy_dly = 3, busy_len = 38, base = 0, nexp = 0, t0 = 0;
  bit busy_en = 1'b1;

  dac_sample_sched #(.NCH(NCH), .DW(DW), .TICK_DIV(TD), .BUSY_TO(BT)) dut (
    .clk50    (clk50),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .ser_start(ser_start),
    .ser_data (ser_data),
    .ser_ch   (ser_ch),
    .ser_busy (ser_busy),
    .overrun  (overrun),
    .timeout  (timeout),
    .clr_err  (clr_err)
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference slot counter: tick is the cycle where it sits at TD-1.
  always @(posedge clk50 or posedge rst)
    if (rst) mcnt <= 0;
    else mcnt <= (mcnt == TD - 1) ? 0 : mcnt + 1;

  always @(negedge clk50) begin
    exp_t e;
    cyc++;
    if (mcnt == TD - 1) tick_cyc = cyc;
    if (ser_start) begin
      nstart++;
      start_cyc = cyc;
      if (sb.size() == 0) check("unexp_start", 32'(ser_ch), 32'hdead);
      else begin
        e = sb.pop_front();
        check("ser_ch", 32'(ser_ch), 32'(e.ch));
        check("ser_data", 32'(ser_data), 32'(e.data));
        check("req_ready", 32'(req_ready), 32'(e.rdy));
        check("latency", cyc - tick_cyc, 2);
      end
    end else if (req_ready != 0) check("stray_ready", 32'(req_ready), 0);
  end

  // Serializer model: busy from busy_dly to busy_dly+busy_len-1 cycles after start.
  always @(negedge clk50) begin
    if (rst || !busy_en) begin
      bcnt = 0;
      ser_busy = 1'b0;
    end else begin
      if (ser_start) bcnt = 1;
      else if (bcnt != 0) bcnt++;
      ser_busy = bcnt >= busy_dly && bcnt < busy_dly + busy_len;
      if (bcnt >= busy_dly + busy_len) bcnt = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk50);
      #1;
    end
  endtask

  task automatic push(input int ch, input int data, input int rdy);
    exp_t e;
    e.ch = 2'(ch);
    e.data = 12'(data);
    e.rdy = 4'(rdy);
    sb.push_back(e);
  endtask

  task automatic set_ch(input int ch, input int val);
    req_data[ch*DW +: DW] = 12'(val);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, 32'(ser_start), 0);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_data"}, 32'(ser_data), 0);
    check({tag, "_ch"}, 32'(ser_ch), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
    check({tag, "_to"}, 32'(timeout), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    busy_en = 1'b1;
    busy_dly = 3;
    busy_len = 38;
    req_valid = '0;
    sb.delete();
    step(2);
    check_zero("rst");
    rst = 1'b0;
  endtask

  task automatic wait_starts(input int tgt);
    int budget;
    budget = (tgt - nstart + 2) * TD * 2;
    while (nstart < tgt && budget > 0) begin
      step(1);
      budget--;
    end
    check("start_cnt", nstart, tgt);
  endtask

  initial begin
    // Single requester, one frame per slot
    do_reset();
    set_ch(2, 'hABC);
    req_valid = 4'b0100;
    repeat (3) push(2, 'hABC, 4'b0100);
    wait_starts(1);
    t0 = start_cyc;
    wait_starts(2);
    check("slot_period1", start_cyc - t0, TD);
    t0 = start_cyc;
    wait_starts(3);
    check("slot_period2", start_cyc - t0, TD);

    // Round-robin over all channels
    do_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, 'h100 + i);
    req_valid = 4'b1111;
    base = nstart;
    foreach (sb[i]) sb.delete(i);
    for (int i = 0; i < 5; i++) push(i % NCH, 'h100 + (i % NCH), 1 << (i % NCH));
    wait_starts(base + 5);

    // Channel 1 drops out and loses its turn
    do_reset();
    req_valid = 4'b1101;
    base = nstart;
    push(0, 'h100, 1);
    push(2, 'h102, 4);
    push(3, 'h103, 8);
    push(0, 'h100, 1);
    wait_starts(base + 4);

    // Overrun: frame outlasts a slot, next tick dropped
    do_reset();
    busy_dly = 1;
    busy_len = 250;
    set_ch(0, 'h055);
    req_valid = 4'b0001;
    base = nstart;
    push(0, 'h055, 1);
    wait_starts(base + 1);
    check("ovr_pre", 32'(overrun), 0);
    push(0, 'h055, 1);
    step(TD);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_dropped", nstart, base + 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("ovr_clr", 32'(overrun), 0);
    wait_starts(base + 2);

    // Timeout: busy never rises
    do_reset();
    busy_en = 1'b0;
    set_ch(1, 'h3C3);
    req_valid = 4'b0010;
    base = nstart;
    push(1, 'h3C3, 2);
    wait_starts(base + 1);
    step(BT);
    check("to_early", 32'(timeout), 0);
    step(1);
    check("to_set", 32'(timeout), 1);
    busy_en = 1'b1;
    push(1, 'h3C3, 2);
    wait_starts(base + 2);
    check("to_sticky", 32'(timeout), 1);

    // No requesters for three slots
    do_reset();
    set_ch(3, 'h777);
    req_valid = 4'b1000;
    base = nstart;
    push(3, 'h777, 8);
    wait_starts(base + 1);
    req_valid = '0;
`ifdef DAC_REFRESH_EN
    repeat (3) push(3, 'h777, 0);
    nexp = base + 4;
`else
    nexp = base + 1;
`endif
    step(3 * TD + 5);
    check("empty_starts", nstart, nexp);
    check("empty_sb", sb.size(), 0);
    check("empty_hold_data", 32'(ser_data), 'h777);
    check("empty_hold_ch", 32'(ser_ch), 3);

    // Async reset mid-frame, then channel 0 first
    do_reset();
    set_ch(2, 'h2A5);
    req_valid = 4'b0100;
    base = nstart;
    push(2, 'h2A5, 4);
    wait_starts(base + 1);
    t0 = 0;
    while (!ser_busy && t0 < 20) begin
      step(1);
      t0++;
    end
    check("busy_seen", 32'(ser_busy), 1);
    step(3);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    step(2);
    for (int i = 0; i < NCH; i++) set_ch(i, 'h100 + i);
    req_valid = 4'b1111;
    rst = 1'b0;
    push(0, 'h100, 1);
    wait_starts(base + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
